// File: rtl/sec_wb_dnsz_if.sv
// Wishbone pipelined bus bundle, parameterised on address and data width.
// The master modport drives the request, the slave modport drives the response.
interface sec_wb_dnsz_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [SEL_WIDTH-1:0]     sel;
    logic                     stall;
    logic                     ack;
    logic                     err;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, err, rdata
    );
endinterface

// File: rtl/sec_wb_dnsz.sv
// Wishbone downsizer: one 128-bit transaction replayed as up to four
// 32-bit narrow beats, then answered with a single assembled wide response.
module sec_wb_dnsz #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned WIDE_DW       = 128,
    parameter int unsigned SMALL_DW      = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    sec_wb_dnsz_if.slave  wide,
    sec_wb_dnsz_if.master narrow
);
    localparam int unsigned NBEAT  = 4;
    localparam int unsigned SEL_W  = SMALL_DW / 8;
    localparam int unsigned WSEL_W = WIDE_DW / 8;
    localparam int unsigned LA_W   = ADDRESS_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [1:0]          beat, beat_nxt;
    logic [NBEAT-1:0]    mask, in_mask;
    logic                we_q, err_q, err_nxt;
    logic [LA_W-1:0]     addr_q;
    logic [WIDE_DW-1:0]  data_q, rbuf;
    logic [WSEL_W-1:0]   sel_q;
    logic                accept;
    logic                first_valid, next_valid;
    logic [1:0]          first_beat, next_beat;
    logic [LA_W-1:0]     addr_src;
    logic [WIDE_DW-1:0]  data_src;
    logic [WSEL_W-1:0]   sel_src;
    logic                we_src;
    logic                unused_addr_hi;

    // The top two wide address bits fall off the narrow address.
    assign unused_addr_hi = ^wide.addr[ADDRESS_WIDTH-1:LA_W];

    assign accept = (state == IDLE) && wide.cyc && wide.stb;
    assign wide.rdata = rbuf;

    // In IDLE the beat lanes come straight from the bus so beat 0 is loaded at accept.
    assign addr_src = (state == IDLE) ? wide.addr[LA_W-1:0] : addr_q;
    assign data_src = (state == IDLE) ? wide.wdata : data_q;
    assign sel_src  = (state == IDLE) ? wide.sel : sel_q;
    assign we_src   = (state == IDLE) ? wide.we : we_q;

    always_comb begin
        in_mask = '0;
        for (int k = 0; k < int'(NBEAT); k++) begin
            in_mask[k] = |wide.sel[k*SEL_W +: SEL_W];
        end
    end

    // Lowest active beat of the incoming request, and next active beat above the current one.
    always_comb begin
        first_valid = 1'b0;
        first_beat  = '0;
        next_valid  = 1'b0;
        next_beat   = '0;
        for (int k = int'(NBEAT) - 1; k >= 0; k--) begin
            if (in_mask[k]) begin
                first_valid = 1'b1;
                first_beat  = 2'(k);
            end
            if (mask[k] && (k > int'(beat))) begin
                next_valid = 1'b1;
                next_beat  = 2'(k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    err_nxt = 1'b0;
                    if (first_valid) begin
                        state_nxt = ISSUE;
                        beat_nxt  = first_beat;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            ISSUE: begin
                if (!wide.cyc) begin
                    state_nxt = IDLE;
                end else if (!narrow.stall) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!wide.cyc) begin
                    state_nxt = IDLE;
                end else if (narrow.err) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end else if (narrow.ack) begin
                    if (next_valid) begin
                        state_nxt = ISSUE;
                        beat_nxt  = next_beat;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            beat         <= '0;
            mask         <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            rbuf         <= '0;
            wide.stall   <= 1'b0;
            wide.ack     <= 1'b0;
            wide.err     <= 1'b0;
            narrow.cyc   <= 1'b0;
            narrow.stb   <= 1'b0;
            narrow.we    <= 1'b0;
            narrow.addr  <= '0;
            narrow.wdata <= '0;
            narrow.sel   <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            err_q <= err_nxt;
            if (accept) begin
                mask   <= in_mask;
                addr_q <= wide.addr[LA_W-1:0];
                data_q <= wide.wdata;
                sel_q  <= wide.sel;
                we_q   <= wide.we;
                rbuf   <= '0;
            end else if ((state == WAIT) && wide.cyc && narrow.ack && !we_q) begin
                rbuf[32'(beat)*SMALL_DW +: SMALL_DW] <= narrow.rdata;
            end

            // Outputs are registered from the next state so they line up with it.
            wide.stall <= (state_nxt != IDLE);
            wide.ack   <= (state_nxt == RESP) && !err_nxt;
            wide.err   <= (state_nxt == RESP) && err_nxt;
            narrow.cyc <= (state_nxt == ISSUE) || (state_nxt == WAIT);
            narrow.stb <= (state_nxt == ISSUE);
            if (state_nxt == ISSUE) begin
                narrow.we    <= we_src;
                narrow.addr  <= {addr_src, beat_nxt};
                narrow.wdata <= data_src[32'(beat_nxt)*SMALL_DW +: SMALL_DW];
                narrow.sel   <= sel_src[32'(beat_nxt)*SEL_W +: SEL_W];
            end else if (state_nxt != WAIT) begin
                narrow.we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sec_wb_dnsz.sv
// Directed bench for sec_wb_dnsz: wide master driver, reactive narrow slave
// with programmable stall/latency/error, and hand-computed expectations.
module tb_sec_wb_dnsz;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    sec_wb_dnsz_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(128)) wide_bus ();
    sec_wb_dnsz_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32))  narrow_bus ();

    sec_wb_dnsz #(
        .ADDRESS_WIDTH(32),
        .WIDE_DW(128),
        .SMALL_DW(32)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .wide  (wide_bus),
        .narrow(narrow_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Narrow slave controls and log of accepted strobes
    int          ack_lat    = 1;
    int          stall_left = 0;
    int          err_beat   = -1;
    logic        stray_ack  = 1'b0;
    logic [31:0] rd_words [4];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [3:0]  log_sel  [$];
    logic        log_we   [$];
    bit          pending  = 0;
    int          wait_left = 0;

    // Observation counters, sampled on the falling edge
    int ack_pulses = 0;
    int err_pulses = 0;
    int stb_cycles = 0;
    int cyc_cycles = 0;

    int           lat;
    logic         got_ack, got_err;
    logic [127:0] got_rd;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wide_bus.ack)   ack_pulses++;
        if (wide_bus.err)   err_pulses++;
        if (narrow_bus.stb) stb_cycles++;
        if (narrow_bus.cyc) cyc_cycles++;
    end

    always @(negedge clk) begin
        logic [31:0] a;
        narrow_bus.ack   = 1'b0;
        narrow_bus.err   = 1'b0;
        narrow_bus.stall = 1'b0;
        narrow_bus.rdata = '0;
        if (stray_ack) narrow_bus.ack = 1'b1;
        if (!narrow_bus.cyc) begin
            pending = 0;
        end else if (narrow_bus.stb) begin
            if (stall_left > 0) begin
                narrow_bus.stall = 1'b1;
                stall_left--;
            end else begin
                log_addr.push_back(narrow_bus.addr);
                log_data.push_back(narrow_bus.wdata);
                log_sel.push_back(narrow_bus.sel);
                log_we.push_back(narrow_bus.we);
                pending   = 1;
                wait_left = ack_lat - 1;
            end
        end else if (pending) begin
            if (wait_left == 0) begin
                pending = 0;
                if (log_addr.size() - 1 == err_beat) begin
                    narrow_bus.err = 1'b1;
                end else begin
                    a = log_addr[log_addr.size()-1];
                    narrow_bus.ack   = 1'b1;
                    narrow_bus.rdata = rd_words[a[1:0]];
                end
            end else begin
                wait_left--;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_sel.delete();
        log_we.delete();
    endtask

    task automatic start_txn(input logic we, input logic [31:0] addr,
                             input logic [127:0] data, input logic [15:0] sel);
        @(negedge clk);
        wide_bus.cyc   = 1'b1;
        wide_bus.stb   = 1'b1;
        wide_bus.we    = we;
        wide_bus.addr  = addr;
        wide_bus.wdata = data;
        wide_bus.sel   = sel;
        @(posedge clk);
        @(negedge clk);
        wide_bus.stb = 1'b0;
    endtask

    // Latency counts cycles after the accept cycle; 0 means no response in budget.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [127:0] data, input logic [15:0] sel);
        start_txn(we, addr, data, sel);
        lat = 0; got_ack = 1'b0; got_err = 1'b0; got_rd = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            if (wide_bus.ack || wide_bus.err) begin
                lat = c; got_ack = wide_bus.ack; got_err = wide_bus.err; got_rd = wide_bus.rdata;
                break;
            end
        end
        if (lat == 0) check("resp_timeout", 1'b0, 1'b1);
        wide_bus.cyc = 1'b0;
    endtask

    // Wait until n beats were strobed and the bridge is waiting on the narrow ack.
    task automatic wait_beats(input int n);
        bit ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (log_addr.size() == n && narrow_bus.cyc && !narrow_bus.stb) begin
                ok = 1;
                break;
            end
        end
        check("wait_beats_reached", 1'(ok), 1'b1);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    int a0, e0, s0, c0;

    initial begin
        wide_bus.cyc = 1'b0; wide_bus.stb = 1'b0; wide_bus.we = 1'b0;
        wide_bus.addr = '0; wide_bus.wdata = '0; wide_bus.sel = '0;
        rd_words[0] = 32'hA0A0_0001; rd_words[1] = 32'hB1B1_0002;
        rd_words[2] = 32'hDEAD_BEEF; rd_words[3] = 32'hD3D3_0004;

        repeat (3) @(negedge clk);
        check("rst_stall", wide_bus.stall, 1'b0);
        check("rst_ack",   {wide_bus.ack, wide_bus.err}, 2'b00);
        check("rst_rdata", wide_bus.rdata, 128'h0);
        check("rst_ncyc",  {narrow_bus.cyc, narrow_bus.stb}, 2'b00);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Full 128-bit write
        clear_log(); a0 = ack_pulses;
        run_txn(1'b1, 32'h10, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        check("full_wr_lat", lat, 9);
        check("full_wr_ack", {got_ack, got_err}, 2'b10);
        check("full_wr_stall_in_resp", wide_bus.stall, 1'b1);
        check("full_wr_nbeats", log_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_addr.size()) begin
                check($sformatf("full_wr_addr%0d", k), log_addr[k], 32'h40 + 32'(k));
                check($sformatf("full_wr_data%0d", k), log_data[k], 32'h11111111 * 32'(k + 1));
                check($sformatf("full_wr_sel%0d", k), log_sel[k], 4'hF);
                check($sformatf("full_wr_we%0d", k), log_we[k], 1'b1);
            end
        end
        settle();
        check("full_wr_stall_after", wide_bus.stall, 1'b0);
        check("full_wr_one_ack", ack_pulses - a0, 1);

        // Sparse read, single middle lane
        clear_log();
        run_txn(1'b0, 32'h10, 128'h0, 16'h0F00);
        check("sparse_rd_lat", lat, 3);
        check("sparse_rd_data", got_rd, 128'h00000000_DEADBEEF_00000000_00000000);
        check("sparse_rd_nbeats", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("sparse_rd_addr", log_addr[0], 32'h42);
            check("sparse_rd_we", log_we[0], 1'b0);
        end
        settle();

        // Zero select: immediate ack, no narrow cycle
        clear_log(); c0 = cyc_cycles;
        run_txn(1'b1, 32'h55, 128'h0, 16'h0000);
        check("zero_sel_lat", lat, 1);
        check("zero_sel_ack", got_ack, 1'b1);
        check("zero_sel_stall", wide_bus.stall, 1'b1);
        settle();
        check("zero_sel_stall_after", wide_bus.stall, 1'b0);
        check("zero_sel_no_cyc", cyc_cycles - c0, 0);

        // Narrow error on beat 1 of a 4-beat write
        clear_log(); err_beat = 1; a0 = ack_pulses; e0 = err_pulses;
        run_txn(1'b1, 32'h10, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        check("err_lat", lat, 5);
        check("err_resp", {got_ack, got_err}, 2'b01);
        settle(); settle();
        check("err_nbeats", log_addr.size(), 2);
        check("err_one_err", err_pulses - e0, 1);
        check("err_no_ack", ack_pulses - a0, 0);
        err_beat = -1;

        // Stall 3 cycles on beat 0 plus 2-cycle ack latency, full read
        clear_log(); stall_left = 3; ack_lat = 2; s0 = stb_cycles;
        run_txn(1'b0, 32'h20, 128'h0, 16'hFFFF);
        check("stall_lat", lat, 16);
        check("stall_rdata", got_rd, 128'hD3D30004_DEADBEEF_B1B10002_A0A00001);
        check("stall_stb_cycles", stb_cycles - s0, 7);
        if (log_addr.size() == 4) check("stall_addr3", log_addr[3], 32'h83);
        settle();
        ack_lat = 1;

        // Two sparse read lanes; buffer cleared from the previous read
        clear_log();
        run_txn(1'b0, 32'h20, 128'h0, 16'hF0F0);
        check("two_lane_lat", lat, 5);
        check("two_lane_rdata", got_rd, 128'hD3D30004_00000000_B1B10002_00000000);
        if (log_addr.size() == 2) check("two_lane_addr1", log_addr[1], 32'h83);
        settle();

        // Wide abort during WAIT of beat 2, with a stray narrow ack afterwards
        clear_log(); ack_lat = 4; a0 = ack_pulses; e0 = err_pulses;
        start_txn(1'b1, 32'h10, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
        wait_beats(3);
        wide_bus.cyc = 1'b0;
        @(negedge clk); #1;
        check("abort_ncyc", {narrow_bus.cyc, narrow_bus.stb}, 2'b00);
        stray_ack = 1'b1;
        @(negedge clk); #1;
        stray_ack = 1'b0;
        repeat (3) settle();
        check("abort_no_resp", (ack_pulses - a0) + (err_pulses - e0), 0);
        check("abort_nbeats", log_addr.size(), 3);
        check("abort_stall", wide_bus.stall, 1'b0);
        ack_lat = 1;

        // Recovery, with top address bits dropped
        clear_log();
        run_txn(1'b1, 32'hC000_0007, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0000, 16'h00F0);
        check("post_abort_lat", lat, 3);
        check("post_abort_ack", {got_ack, got_err}, 2'b10);
        if (log_addr.size() == 1) begin
            check("post_abort_addr", log_addr[0], 32'h1D);
            check("post_abort_data", log_data[0], 32'hCAFEF00D);
        end
        settle();

        // Reset pulsed mid-burst
        clear_log(); ack_lat = 3; a0 = ack_pulses; e0 = err_pulses;
        start_txn(1'b0, 32'h10, 128'h0, 16'hFFFF);
        wait_beats(2);
        rstn = 1'b0;
        #1;
        check("rst_mid_ncyc", {narrow_bus.cyc, narrow_bus.stb}, 2'b00);
        check("rst_mid_stall", wide_bus.stall, 1'b0);
        wide_bus.cyc = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) settle();
        check("rst_mid_no_resp", (ack_pulses - a0) + (err_pulses - e0), 0);
        ack_lat = 1;

        clear_log();
        run_txn(1'b0, 32'h10, 128'h0, 16'h000F);
        check("post_rst_lat", lat, 3);
        check("post_rst_rdata", got_rd, 128'h00000000_00000000_00000000_A0A00001);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
